l2_cache_wb: RTL and testbench
==============================

Name: l2_cache_wb

Overview:
- Parametrised set-associative L2 cache: write-back, write-allocate, with dirty-victim eviction to memory.
- Sits between the L1 cache (L1-block-granular requests) and main memory (L2-block-granular transfers).
- Generalises the existing read-only L2 in four ways:
  - L1 writes are handled.
  - Lookup latency is configurable.
  - Replacement policy is selectable.
  - Dirty victims are written back before refill.
- All addresses are word addresses.

Parameters:
- DATA_WIDTH, 32, bits per word.
- ADDR_WIDTH, 32, word-address width.
- CACHE_SIZE, 1024, total capacity in words.
- BLOCK_SIZE, 16, words per L2 line; power of 2.
- NUM_WAYS, 4, associativity; power of 2, 1..16.
- L1_BLOCK_SIZE, 4, words per L1 request; power of 2, <= BLOCK_SIZE.
- HIT_LATENCY, 2, LOOKUP wait cycles before the hit/miss decision; 0..15.
- REPL_POLICY, 0, 0 = random (random_num), 1 = per-set round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- random_num  in  4  victim select when REPL_POLICY=0; low log2(NUM_WAYS) bits used
- l2_cache_addr  in  ADDR_WIDTH  request word address
- l2_cache_data_in  in  L1_BLOCK_SIZE*DATA_WIDTH  write data; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- l2_cache_data_out  out  L1_BLOCK_SIZE*DATA_WIDTH  read data
- l2_cache_read  in  1  read request
- l2_cache_write  in  1  write request
- l2_cache_ready  out  1  one-cycle completion pulse
- l2_hit  out  1  qualifies ready: 1 = request hit in L2
- mem_addr  out  ADDR_WIDTH  block-aligned memory address
- mem_data_out  out  BLOCK_SIZE*DATA_WIDTH  write-back data
- mem_data_in  in  BLOCK_SIZE*DATA_WIDTH  refill data
- mem_read  out  1  refill request, level-held
- mem_write  out  1  write-back request, level-held
- mem_ready  in  1  memory completion, one cycle

Behaviour:

Address and sizing:
- offset = addr[log2(BLOCK_SIZE)-1:0]; index is the next log2(NUM_SETS) bits; tag is the rest.
- NUM_SETS = CACHE_SIZE/BLOCK_SIZE/NUM_WAYS.
- Sub-block start = offset with its low log2(L1_BLOCK_SIZE) bits cleared.

Reset (rst high at a clock edge, including mid-transaction):
- All valid, dirty and round-robin pointers cleared; state to IDLE.
- l2_cache_ready, l2_hit, mem_read, mem_write = 0.
- mem_addr, mem_data_out, l2_cache_data_out = 0.
- An in-flight memory transaction is abandoned. Memory must tolerate the request dropping.

States: IDLE, LOOKUP, WRITEBACK, ALLOCATE.

IDLE:
- If read or write is high, latch addr, data and op (write wins if both are high), load the wait counter with HIT_LATENCY, and go to LOOKUP.
- The requester deasserts read/write in the cycle it sees ready. A request still held there is accepted again as new.

LOOKUP:
- Decrement the counter while it is nonzero. Decide when it is 0, so total latency is HIT_LATENCY+1 cycles after acceptance.
- Hit, read: drive data_out with the L1 sub-block; pulse ready=1 and l2_hit=1; go to IDLE.
- Hit, write: merge the sub-block into the line and set dirty; pulse ready/l2_hit; data_out unchanged; go to IDLE.
- Miss: select a victim.
  - Victim valid and dirty: go to WRITEBACK; mem_addr = {victim tag, index, 0}; mem_data_out = victim line; mem_write=1.
  - Otherwise: go to ALLOCATE; mem_addr = {tag, index, 0}; mem_read=1.

WRITEBACK:
- Hold mem_write, mem_addr and mem_data_out until mem_ready.
- On mem_ready: mem_write=0, clear the victim's dirty bit, set mem_addr to the refill address, mem_read=1, go to ALLOCATE.

ALLOCATE:
- Hold until mem_ready.
- On mem_ready:
  - Write the line from mem_data_in; set tag and valid.
  - Write request: merge the latched sub-block over the refill data in the same cycle and set dirty=1. Read request: dirty=0.
  - data_out = sub-block of the merged line.
  - mem_read=0; pulse ready=1 with l2_hit=0; go to IDLE.

Victim selection:
- The lowest-index invalid way always wins.
- Otherwise REPL_POLICY selects the way:
  - 0: way = random_num sampled in the LOOKUP decision cycle.
  - 1: way = the set's pointer. The pointer increments mod NUM_WAYS on each replacement of a valid line in that set.

Invariants:
- mem_read and mem_write are never high together.
- ready and l2_hit are pulses lasting exactly 1 cycle.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- Request inputs outside IDLE are ignored.
- HIT_LATENCY=0 gives a 2-cycle hit from request to ready.

Test Plan:
1. Reset, then read 0x100 with mem_data_in word k = 0x1000+k.
   - Required: mem_read with mem_addr=0x100, no mem_write.
   - Ready with l2_hit=0 and data_out words 0x1000..0x1003.
   - Re-reading 0x104 gives ready 3 cycles after acceptance, l2_hit=1, data 0x1004..0x1007.
2. Write 0x108 with data AAAA0000..AAAA0003 after case 1.
   - Required: hit; ready, l2_hit=1; no memory access.
   - Read 0x108 returns AAAA0000..AAAA0003.
3. REPL_POLICY=1. Read 0x000, 0x100, 0x200, 0x300 (all set 0), dirty 0x100 via a write, then read 0x400 twice.
   - Required: the first 0x400 evicts way 0 (clean), so no write-back.
   - The second hits.
   - A later read of 0x500 evicts way 1 (0x100): mem_write, mem_addr=0x100 with the written data, then mem_read at 0x500.
4. Write-miss to 0x600.
   - Required: refill read, merged line marked dirty.
   - A subsequent eviction writes back the merged line.
5. Assert rst during WRITEBACK with mem_ready held low.
   - Required: next cycle mem_write=0 and state IDLE.
   - A read of the previously cached address then misses.
6. read=write=1 simultaneously.
   - Required: treated as a write.
   - Request held past ready is accepted as a second transaction.

Source files
------------

// File: rtl/l2_cache_wb.sv
// Set-associative write-back / write-allocate L2 cache between an L1 (sub-block requests)
// and main memory (full-line transfers), with dirty-victim write-back before refill.
module l2_cache_wb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int CACHE_SIZE    = 1024,
    parameter int BLOCK_SIZE    = 16,
    parameter int NUM_WAYS      = 4,
    parameter int L1_BLOCK_SIZE = 4,
    parameter int HIT_LATENCY   = 2,
    parameter int REPL_POLICY   = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [3:0]                          random_num,
    input  logic [ADDR_WIDTH-1:0]               l2_cache_addr,
    input  logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_in,
    output logic [L1_BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_out,
    input  logic                                l2_cache_read,
    input  logic                                l2_cache_write,
    output logic                                l2_cache_ready,
    output logic                                l2_hit,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0]    mem_data_out,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]    mem_data_in,
    output logic                                mem_read,
    output logic                                mem_write,
    input  logic                                mem_ready
);

    localparam int NUM_SETS  = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF_W     = $clog2(BLOCK_SIZE);
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int IDX_W     = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_BITS;
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int SUB_W     = $clog2(L1_BLOCK_SIZE);
    localparam int NUM_SUB   = BLOCK_SIZE / L1_BLOCK_SIZE;
    localparam int SEL_W     = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
    localparam int SUB_BITS  = L1_BLOCK_SIZE * DATA_WIDTH;
    localparam int LINE_BITS = BLOCK_SIZE * DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SUB_BITS-1:0]   wdata_q, wdata_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  ready_q, ready_d;
    logic                  hit_q, hit_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]  mem_data_out_q, mem_data_out_d;
    logic [SUB_BITS-1:0]   data_out_q, data_out_d;

    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [WAY_W-1:0]      rr_q    [NUM_SETS];
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0]  data_q  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0]      set_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [SEL_W-1:0]      sub_sel;
    logic                  hit_any, inv_any;
    logic [WAY_W-1:0]      hit_way, inv_way, victim_way;
    logic [ADDR_WIDTH-1:0] refill_addr, victim_addr;
    logic [LINE_BITS-1:0]  hit_line, fill_line;

    logic                  line_we;
    logic [WAY_W-1:0]      line_way;
    logic [LINE_BITS-1:0]  line_wdata;
    logic                  dirty_we, dirty_val;
    logic [WAY_W-1:0]      dirty_way;
    logic                  rr_inc;

    function automatic logic [SUB_BITS-1:0] get_sub(input logic [LINE_BITS-1:0] line,
                                                    input logic [SEL_W-1:0] sel);
        return line[int'(sel)*SUB_BITS +: SUB_BITS];
    endfunction

    function automatic logic [LINE_BITS-1:0] merge_sub(input logic [LINE_BITS-1:0] line,
                                                       input logic [SEL_W-1:0] sel,
                                                       input logic [SUB_BITS-1:0] d);
        logic [LINE_BITS-1:0] r;
        r = line;
        r[int'(sel)*SUB_BITS +: SUB_BITS] = d;
        return r;
    endfunction

    always_comb begin
        set_idx = (NUM_SETS == 1) ? '0 : IDX_W'(addr_q >> OFF_W);
        req_tag = TAG_W'(addr_q >> (OFF_W + IDX_BITS));
        sub_sel = (NUM_SUB == 1) ? '0 : SEL_W'(addr_q >> SUB_W);
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit_any && valid_q[set_idx][w] && tag_q[set_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_any && !valid_q[set_idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        if (inv_any)
            victim_way = inv_way;
        else if (REPL_POLICY == 1)
            victim_way = rr_q[set_idx];
        else
            victim_way = WAY_W'(32'(random_num) % NUM_WAYS);
        hit_line    = data_q[set_idx][hit_way];
        refill_addr = (ADDR_WIDTH'(req_tag) << (OFF_W + IDX_BITS))
                    | (ADDR_WIDTH'(set_idx) << OFF_W);
        victim_addr = (ADDR_WIDTH'(tag_q[set_idx][victim_way]) << (OFF_W + IDX_BITS))
                    | (ADDR_WIDTH'(set_idx) << OFF_W);
        fill_line   = op_wr_q ? merge_sub(mem_data_in, sub_sel, wdata_q) : mem_data_in;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        op_wr_d        = op_wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        victim_d       = victim_q;
        ready_d        = 1'b0;
        hit_d          = 1'b0;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        data_out_d     = data_out_q;
        line_we        = 1'b0;
        line_way       = '0;
        line_wdata     = '0;
        dirty_we       = 1'b0;
        dirty_val      = 1'b0;
        dirty_way      = '0;
        rr_inc         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (l2_cache_read || l2_cache_write) begin
                    addr_d  = l2_cache_addr;
                    wdata_d = l2_cache_data_in;
                    op_wr_d = l2_cache_write;
                    cnt_d   = 4'(HIT_LATENCY);
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (hit_any) begin
                    if (op_wr_q) begin
                        line_we    = 1'b1;
                        line_way   = hit_way;
                        line_wdata = merge_sub(hit_line, sub_sel, wdata_q);
                        dirty_we   = 1'b1;
                        dirty_val  = 1'b1;
                        dirty_way  = hit_way;
                    end else begin
                        data_out_d = get_sub(hit_line, sub_sel);
                    end
                    ready_d = 1'b1;
                    hit_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    victim_d = victim_way;
                    rr_inc   = !inv_any && (REPL_POLICY == 1) && (NUM_WAYS > 1);
                    if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
                        mem_addr_d     = victim_addr;
                        mem_data_out_d = data_q[set_idx][victim_way];
                        mem_write_d    = 1'b1;
                        state_d        = S_WRITEBACK;
                    end else begin
                        mem_addr_d = refill_addr;
                        mem_read_d = 1'b1;
                        state_d    = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    dirty_we    = 1'b1;
                    dirty_val   = 1'b0;
                    dirty_way   = victim_q;
                    mem_addr_d  = refill_addr;
                    mem_read_d  = 1'b1;
                    state_d     = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (mem_ready) begin
                    line_we    = 1'b1;
                    line_way   = victim_q;
                    line_wdata = fill_line;
                    dirty_we   = 1'b1;
                    dirty_val  = op_wr_q;
                    dirty_way  = victim_q;
                    data_out_d = get_sub(fill_line, sub_sel);
                    mem_read_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            op_wr_q        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            victim_q       <= '0;
            ready_q        <= 1'b0;
            hit_q          <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            data_out_q     <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_wr_q        <= op_wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            victim_q       <= victim_d;
            ready_q        <= ready_d;
            hit_q          <= hit_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            data_out_q     <= data_out_d;
            if (line_we)
                valid_q[set_idx][line_way] <= 1'b1;
            if (dirty_we)
                dirty_q[set_idx][dirty_way] <= dirty_val;
            if (rr_inc)
                rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
        end
    end

    // Line storage carries no reset; validity alone decides whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && line_we) begin
            data_q[set_idx][line_way] <= line_wdata;
            tag_q[set_idx][line_way]  <= req_tag;
        end
    end

    assign l2_cache_ready    = ready_q;
    assign l2_hit            = hit_q;
    assign mem_read          = mem_read_q;
    assign mem_write         = mem_write_q;
    assign mem_addr          = mem_addr_q;
    assign mem_data_out      = mem_data_out_q;
    assign l2_cache_data_out = data_out_q;

endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed bench for l2_cache_wb (round-robin replacement, 2-cycle lookup wait);
// the memory side answers every request on the following cycle.
module tb_l2_cache_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   random_num = 4'h5;
    logic [31:0]  l2_cache_addr = '0;
    logic [127:0] l2_cache_data_in = '0;
    logic [127:0] l2_cache_data_out;
    logic         l2_cache_read = 1'b0;
    logic         l2_cache_write = 1'b0;
    logic         l2_cache_ready;
    logic         l2_hit;
    logic [31:0]  mem_addr;
    logic [511:0] mem_data_out;
    logic [511:0] mem_data_in = '0;
    logic         mem_read;
    logic         mem_write;
    logic         mem_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    localparam logic [511:0] Z = '0;

    l2_cache_wb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CACHE_SIZE(1024), .BLOCK_SIZE(16),
        .NUM_WAYS(4), .L1_BLOCK_SIZE(4), .HIT_LATENCY(2), .REPL_POLICY(1)
    ) dut (
        .clk(clk), .rst(rst), .random_num(random_num),
        .l2_cache_addr(l2_cache_addr), .l2_cache_data_in(l2_cache_data_in),
        .l2_cache_data_out(l2_cache_data_out), .l2_cache_read(l2_cache_read),
        .l2_cache_write(l2_cache_write), .l2_cache_ready(l2_cache_ready), .l2_hit(l2_hit),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory returns word k of block at address a as (a << 4) + k.
    function automatic logic [511:0] fill(input logic [31:0] a);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = (a << 4) + 32'(k);
        return l;
    endfunction

    function automatic logic [127:0] seq4(input logic [31:0] b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = b + 32'(k);
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xact(input string tag, input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [127:0] wd, input bit keep, input bit exp_hit,
                        input bit chk_data, input logic [127:0] exp_data,
                        input bit exp_wb, input logic [31:0] exp_wb_addr,
                        input logic [511:0] exp_wb_data, input bit exp_rf,
                        input logic [31:0] exp_rf_addr, input int exp_cycles);
        int cycles;
        bit got, wb_seen, rf_seen;
        logic [31:0] wb_a, rf_a;
        logic [511:0] wb_d;
        cycles = 0; got = 0; wb_seen = 0; rf_seen = 0; wb_a = '0; rf_a = '0; wb_d = '0;
        @(negedge clk);
        l2_cache_read = rd; l2_cache_write = wr; l2_cache_addr = addr; l2_cache_data_in = wd;
        while (!got && cycles < 100) begin
            @(negedge clk);
            cycles++;
            mem_ready = 1'b0;
            chk({tag, " rw_excl"}, 512'(mem_read && mem_write), Z);
            if (l2_cache_ready) begin
                got = 1;
            end else if (mem_write) begin
                if (!wb_seen) begin wb_a = mem_addr; wb_d = mem_data_out; end
                wb_seen = 1; mem_ready = 1'b1;
            end else if (mem_read) begin
                if (!rf_seen) rf_a = mem_addr;
                rf_seen = 1; mem_data_in = fill(mem_addr); mem_ready = 1'b1;
            end
        end
        chk({tag, " ready_seen"}, 512'(got), 512'(1));
        if (!keep) begin l2_cache_read = 1'b0; l2_cache_write = 1'b0; end
        chk({tag, " l2_hit"}, 512'(l2_hit), 512'(exp_hit));
        if (chk_data) chk({tag, " data_out"}, 512'(l2_cache_data_out), 512'(exp_data));
        chk({tag, " wb_seen"}, 512'(wb_seen), 512'(exp_wb));
        if (exp_wb) begin
            chk({tag, " wb_addr"}, 512'(wb_a), 512'(exp_wb_addr));
            chk({tag, " wb_data"}, wb_d, exp_wb_data);
        end
        chk({tag, " rf_seen"}, 512'(rf_seen), 512'(exp_rf));
        if (exp_rf) chk({tag, " rf_addr"}, 512'(rf_a), 512'(exp_rf_addr));
        if (exp_cycles >= 0) chk({tag, " latency"}, 512'(cycles), 512'(exp_cycles));
        if (!keep) begin
            @(negedge clk);
            chk({tag, " ready_pulse"}, 512'({l2_cache_ready, l2_hit}), Z);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [511:0] l100, l600, l700;
        bit seen;

        // Case 1: cold miss then sub-block hit
        repeat (2) @(negedge clk);
        chk("rst ready/hit", 512'({l2_cache_ready, l2_hit}), Z);
        chk("rst mem_rw", 512'({mem_read, mem_write}), Z);
        chk("rst mem_addr", 512'(mem_addr), Z);
        chk("rst data_out", 512'(l2_cache_data_out), Z);
        chk("rst mem_data_out", mem_data_out, Z);
        rst = 1'b0;
        xact("c1 rd100", 0, 1, 32'h100, '0, 0, 0, 1, seq4(32'h1000), 0, '0, Z, 1, 32'h100, -1);
        xact("c1 rd104", 0, 1, 32'h104, '0, 0, 1, 1, seq4(32'h1004), 0, '0, Z, 0, '0, 4);

        // Case 2: write hit, no memory traffic
        xact("c2 wr108", 1, 0, 32'h108, seq4(32'hAAAA0000), 0, 1, 0, '0, 0, '0, Z, 0, '0, 4);
        xact("c2 rd108", 0, 1, 32'h108, '0, 0, 1, 1, seq4(32'hAAAA0000), 0, '0, Z, 0, '0, 4);

        // Case 3: round-robin replacement in set 0
        do_reset();
        xact("c3 rd000", 0, 1, 32'h000, '0, 0, 0, 1, seq4(32'h0000), 0, '0, Z, 1, 32'h000, -1);
        xact("c3 rd100", 0, 1, 32'h100, '0, 0, 0, 1, seq4(32'h1000), 0, '0, Z, 1, 32'h100, -1);
        xact("c3 rd200", 0, 1, 32'h200, '0, 0, 0, 1, seq4(32'h2000), 0, '0, Z, 1, 32'h200, -1);
        xact("c3 rd300", 0, 1, 32'h300, '0, 0, 0, 1, seq4(32'h3000), 0, '0, Z, 1, 32'h300, -1);
        xact("c3 wr104", 1, 0, 32'h104, seq4(32'hBBBB0000), 0, 1, 0, '0, 0, '0, Z, 0, '0, 4);
        xact("c3 rd400a", 0, 1, 32'h400, '0, 0, 0, 1, seq4(32'h4000), 0, '0, Z, 1, 32'h400, -1);
        xact("c3 rd400b", 0, 1, 32'h400, '0, 0, 1, 1, seq4(32'h4000), 0, '0, Z, 0, '0, 4);
        l100 = fill(32'h100);
        l100[128 +: 128] = seq4(32'hBBBB0000);
        xact("c3 rd500", 0, 1, 32'h500, '0, 0, 0, 1, seq4(32'h5000), 1, 32'h100, l100, 1, 32'h500, -1);

        // Case 4: write miss allocates a dirty merged line, later written back
        xact("c4 wr60C", 1, 0, 32'h60C, seq4(32'hCCCC0000), 0, 0, 1, seq4(32'hCCCC0000), 0, '0, Z, 1, 32'h600, -1);
        xact("c4 rd60C", 0, 1, 32'h60C, '0, 0, 1, 1, seq4(32'hCCCC0000), 0, '0, Z, 0, '0, 4);
        xact("c4 rd700", 0, 1, 32'h700, '0, 0, 0, 1, seq4(32'h7000), 0, '0, Z, 1, 32'h700, -1);
        xact("c4 rd800", 0, 1, 32'h800, '0, 0, 0, 1, seq4(32'h8000), 0, '0, Z, 1, 32'h800, -1);
        xact("c4 rd900", 0, 1, 32'h900, '0, 0, 0, 1, seq4(32'h9000), 0, '0, Z, 1, 32'h900, -1);
        l600 = fill(32'h600);
        l600[384 +: 128] = seq4(32'hCCCC0000);
        xact("c4 rdA00", 0, 1, 32'hA00, '0, 0, 0, 1, seq4(32'hA000), 1, 32'h600, l600, 1, 32'hA00, -1);

        // Case 5: reset while a write-back is pending
        xact("c5 wr700", 1, 0, 32'h700, seq4(32'hEEEE0000), 0, 1, 0, '0, 0, '0, Z, 0, '0, 4);
        l700 = fill(32'h700);
        l700[0 +: 128] = seq4(32'hEEEE0000);
        @(negedge clk);
        l2_cache_read = 1'b1; l2_cache_addr = 32'hB00;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_write) seen = 1;
        end
        chk("c5 wb_start", 512'(seen), 512'(1));
        l2_cache_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("c5 wb_held", 512'({mem_write, mem_read}), 512'(2'b10));
        chk("c5 wb_addr", 512'(mem_addr), 512'(32'h700));
        chk("c5 wb_data", mem_data_out, l700);
        rst = 1'b1;
        @(negedge clk);
        chk("c5 rst mem_rw", 512'({mem_read, mem_write}), Z);
        chk("c5 rst mem_addr", 512'(mem_addr), Z);
        chk("c5 rst ready", 512'({l2_cache_ready, l2_hit}), Z);
        chk("c5 rst data_out", 512'(l2_cache_data_out), Z);
        rst = 1'b0;
        xact("c5 rd700", 0, 1, 32'h700, '0, 0, 0, 1, seq4(32'h7000), 0, '0, Z, 1, 32'h700, -1);

        // Case 6: simultaneous read+write is a write; held request re-accepted
        xact("c6 rw700a", 1, 1, 32'h700, seq4(32'hFFFF0000), 1, 1, 0, '0, 0, '0, Z, 0, '0, 4);
        xact("c6 rw700b", 1, 1, 32'h700, seq4(32'hFFFF0000), 0, 1, 0, '0, 0, '0, Z, 0, '0, 3);
        xact("c6 rd700", 0, 1, 32'h700, '0, 0, 1, 1, seq4(32'hFFFF0000), 0, '0, Z, 0, '0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
